// File: rtl/lab3_serial_pattern_tx.sv
// rtl/lab3_serial_pattern_tx.sv - MSB-first serial word transmitter with bit stretch and idle gap
// Drives the single-bit stimulus input of the Lab3 Mealy sequence detector.
module lab3_serial_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter int   DIV_CYCLES = 1,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             bit_stb,
  output logic             frame,
  output logic             done
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(DIV_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             x_out_q, x_out_d;
  logic             bit_stb_q, bit_stb_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;

  assign in_ready = (state_q == ST_IDLE);
  assign x_out    = x_out_q;
  assign bit_stb  = bit_stb_q;
  assign frame    = frame_q;
  assign done     = done_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    x_out_d   = x_out_q;
    bit_stb_d = 1'b0;
    frame_d   = frame_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        x_out_d = IDLE_LEVEL;
        frame_d = 1'b0;
        if (in_valid) begin
          state_d   = ST_SHIFT;
          shift_d   = in_data;
          x_out_d   = in_data[WIDTH-1];
          bit_stb_d = 1'b1;
          frame_d   = 1'b1;
          cyc_cnt_d = '0;
          bit_cnt_d = BIT_LAST;
        end
      end

      ST_SHIFT: begin
        if (cyc_cnt_q == CYC_LAST) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q == '0) begin
            x_out_d = IDLE_LEVEL;
            frame_d = 1'b0;
            if (GAP_CYCLES > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            // Rotating rather than zero-filling keeps every register bit live; the
            // wrapped-around bit is never transmitted.
            bit_cnt_d = bit_cnt_q - 1'b1;
            shift_d   = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
            x_out_d   = shift_q[WIDTH-2];
            bit_stb_d = 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        x_out_d = IDLE_LEVEL;
        frame_d = 1'b0;
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        x_out_d = IDLE_LEVEL;
        frame_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      x_out_q   <= IDLE_LEVEL;
      bit_stb_q <= 1'b0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      x_out_q   <= x_out_d;
      bit_stb_q <= bit_stb_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_lab3_serial_pattern_tx.sv
// tb/tb_lab3_serial_pattern_tx.sv - table, directed and random checks of lab3_serial_pattern_tx
// Four instances with different shapes share the clock and reset.
module tb_lab3_serial_pattern_tx;

  logic       clk;
  logic       resetn;
  logic [3:0] in_valid;
  logic [7:0] in_data [4];
  logic [3:0] rdy, xo, stb, frm, dn;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int Wv [4] = '{4, 4, 4, 8};
  int Dv [4] = '{1, 3, 1, 2};
  int Gv [4] = '{2, 2, 0, 1};
  int Lv [4] = '{0, 0, 0, 1};

  // Model: mt = clocks since accept (-1 when idle), mw = captured word
  int         mt [4] = '{-1, -1, -1, -1};
  logic [7:0] mw [4];

  typedef struct {
    int         inst;
    logic       vld;
    logic [7:0] data;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl [$];

  lab3_serial_pattern_tx #(.WIDTH(4), .DIV_CYCLES(1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u0 (
    .clock(clk), .reset(resetn), .in_data(in_data[0][3:0]), .in_valid(in_valid[0]),
    .in_ready(rdy[0]), .x_out(xo[0]), .bit_stb(stb[0]), .frame(frm[0]), .done(dn[0]));
  lab3_serial_pattern_tx #(.WIDTH(4), .DIV_CYCLES(3), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u1 (
    .clock(clk), .reset(resetn), .in_data(in_data[1][3:0]), .in_valid(in_valid[1]),
    .in_ready(rdy[1]), .x_out(xo[1]), .bit_stb(stb[1]), .frame(frm[1]), .done(dn[1]));
  lab3_serial_pattern_tx #(.WIDTH(4), .DIV_CYCLES(1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u2 (
    .clock(clk), .reset(resetn), .in_data(in_data[2][3:0]), .in_valid(in_valid[2]),
    .in_ready(rdy[2]), .x_out(xo[2]), .bit_stb(stb[2]), .frame(frm[2]), .done(dn[2]));
  lab3_serial_pattern_tx #(.WIDTH(8), .DIV_CYCLES(2), .GAP_CYCLES(1), .IDLE_LEVEL(1'b1)) u3 (
    .clock(clk), .reset(resetn), .in_data(in_data[3]), .in_valid(in_valid[3]),
    .in_ready(rdy[3]), .x_out(xo[3]), .bit_stb(stb[3]), .frame(frm[3]), .done(dn[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tot(int i);
    return Wv[i] * Dv[i] + Gv[i];
  endfunction

  // {in_ready, x_out, bit_stb, frame, done}
  function automatic logic [4:0] got(int i);
    return {rdy[i], xo[i], stb[i], frm[i], dn[i]};
  endfunction

  function automatic logic [4:0] exp_out(int i);
    int   t  = mt[i];
    int   bp = Wv[i] * Dv[i];
    logic il = Lv[i][0];
    if (t < 0) return {1'b1, il, 3'b000};
    if (t < bp) return {1'b0, mw[i][Wv[i] - 1 - t / Dv[i]], (t % Dv[i]) == 0, 1'b1, 1'b0};
    if (t < bp + Gv[i]) return {1'b0, il, 3'b000};
    return {1'b1, il, 3'b001};
  endfunction

  task automatic check(string nm, int i, logic [4:0] g, logic [4:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%b exp=%b (ready,x,stb,frame,done)", nm, i, cyc, g, e);
    end
  endtask

  task automatic add(int inst, logic v, logic [7:0] d, logic [4:0] e);
    vec_t r;
    r.inst = inst; r.vld = v; r.data = d; r.exp = e;
    tbl.push_back(r);
  endtask

  // One clock: inputs present before the edge are what the model consumes.
  task automatic step();
    logic       r;
    logic [3:0] v;
    logic [7:0] d [4];
    r = resetn;
    v = in_valid;
    for (int i = 0; i < 4; i++) d[i] = in_data[i];
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (!r) mt[i] = -1;
      else if ((mt[i] < 0 || mt[i] == tot(i)) && v[i]) begin
        mt[i] = 0;
        mw[i] = d[i];
      end else if (mt[i] >= 0) mt[i] = (mt[i] == tot(i)) ? -1 : mt[i] + 1;
      check("model", i, got(i), exp_out(i));
    end
  endtask

  initial begin
    logic [3:0] coll;
    int         nstb, nfrm;
    logic       prev;

    resetn   = 1'b0;
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) in_data[i] = 8'hA5;

    // Reset with in_valid high: no accept, idle outputs
    step();
    step();
    for (int i = 0; i < 4; i++) check("reset", i, got(i), {1'b1, Lv[i][0], 3'b000});
    in_valid = 4'h0;
    resetn   = 1'b1;
    step();
    for (int i = 0; i < 4; i++) check("post_reset", i, got(i), {1'b1, Lv[i][0], 3'b000});

    // Basic frame 1011, DIV=1 GAP=2
    add(0, 1, 8'h0B, 5'b01110); add(0, 0, 8'h0B, 5'b00110); add(0, 0, 8'h0B, 5'b01110);
    add(0, 0, 8'h0B, 5'b01110); add(0, 0, 8'h0B, 5'b00000); add(0, 0, 8'h0B, 5'b00000);
    add(0, 0, 8'h0B, 5'b10001); add(0, 0, 8'h0B, 5'b10000);
    // Bit stretch 1100, DIV=3 GAP=2
    add(1, 1, 8'h0C, 5'b01110); add(1, 0, 8'h0C, 5'b01010); add(1, 0, 8'h0C, 5'b01010);
    add(1, 0, 8'h0C, 5'b01110); add(1, 0, 8'h0C, 5'b01010); add(1, 0, 8'h0C, 5'b01010);
    add(1, 0, 8'h0C, 5'b00110); add(1, 0, 8'h0C, 5'b00010); add(1, 0, 8'h0C, 5'b00010);
    add(1, 0, 8'h0C, 5'b00110); add(1, 0, 8'h0C, 5'b00010); add(1, 0, 8'h0C, 5'b00010);
    add(1, 0, 8'h0C, 5'b00000); add(1, 0, 8'h0C, 5'b00000); add(1, 0, 8'h0C, 5'b10001);
    // Back-to-back 0010 then 1110, GAP=0, in_valid held
    add(2, 1, 8'h02, 5'b00110); add(2, 1, 8'h0E, 5'b00110); add(2, 1, 8'h0E, 5'b01110);
    add(2, 1, 8'h0E, 5'b00110); add(2, 1, 8'h0E, 5'b10001); add(2, 1, 8'h0E, 5'b01110);
    add(2, 1, 8'h0E, 5'b01110); add(2, 1, 8'h0E, 5'b01110); add(2, 1, 8'h0E, 5'b00110);
    add(2, 1, 8'h0E, 5'b10001); add(2, 0, 8'h0E, 5'b10000);

    for (int k = 0; k < tbl.size(); k++) begin
      in_valid = 4'h0;
      in_valid[tbl[k].inst] = tbl[k].vld;
      in_data[tbl[k].inst]  = tbl[k].data;
      step();
      check("table", tbl[k].inst, got(tbl[k].inst), tbl[k].exp);
    end
    in_valid = 4'h0;

    // Busy-ignore: in_data goes to F with in_valid high mid-frame
    coll = 4'h0; nstb = 0; nfrm = 0; prev = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid[0] = (k < 4);
      in_data[0]  = (k == 0) ? 8'h05 : 8'h0F;
      step();
      if (stb[0]) begin
        coll = {coll[2:0], xo[0]};
        nstb++;
      end
      if (frm[0] && !prev) nfrm++;
      prev = frm[0];
    end
    check("busy_bits", 0, {1'b0, coll}, 5'b00101);
    check("busy_stb", 0, 5'(nstb), 5'd4);
    check("busy_frames", 0, 5'(nfrm), 5'd1);
    in_valid = 4'h0;

    // Mid-frame reset after E2
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h0B;
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    resetn = 1'b0;
    step();
    check("midframe_reset", 0, got(0), 5'b10000);
    resetn = 1'b1;
    step();
    check("after_midreset", 0, got(0), 5'b10000);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      resetn = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 4; i++) begin
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_data[i]  = 8'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
